r200_mem: RTL and testbench
===========================

# r200_mem

Memory-access stage of the r200 RV32I pipeline, directly downstream of the execute stage. It takes the ALU result, store data and func3 for one instruction per handshake. It performs loads and stores on a single-outstanding data-memory bus with byte lanes and load sign/zero extension, and hands a registered writeback result to the WB stage. Non-memory instructions pass the ALU result through with one cycle of latency.

## Interface
- ACK_TIMEOUT, 255: cycles `dmem_req` may stay high without `dmem_ack` before a bus-timeout exception (1..65535).

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX presents an instruction
- ex_ready  out  1  stage accepts; transfer when ex_valid && ex_ready
- ex_alu_res  in  32  ALU result (effective address for loads/stores)
- ex_store_data  in  32  rs2 value for stores
- ex_func3  in  3  instr[14:12]
- ex_load  in  1  instruction is a load
- ex_store  in  1  instruction is a store
- ex_rd  in  5  destination register
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, bits [1:0] forced to 0
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  bus completion; rdata valid same cycle
- dmem_rdata  in  32  read word
- wb_valid  out  1  result valid
- wb_ready  in  1  WB accepts; transfer when wb_valid && wb_ready
- wb_result  out  32  writeback value
- wb_rd  out  5  destination register (0 for stores)
- wb_exc  out  1  exception flag
- wb_exc_code  out  2  1 misaligned, 2 bus timeout, 3 illegal access

## Operation
- FSM states: IDLE, BUS, HOLD.
- ex_ready = (state==IDLE) && (!wb_valid || wb_ready).
- IDLE, accept, non-memory (ex_load==ex_store==0): wb_result<=ex_alu_res, wb_rd<=ex_rd, wb_valid<=1. Stay in IDLE.
- IDLE, accept, memory op: check legality first.
  - Both ex_load and ex_store high, a load func3 not in {0,1,2,4,5}, or a store func3 not in {0,1,2}: immediate writeback with wb_exc=1, code 3, wb_result=0.
  - Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0. Immediate writeback with code 1, wb_result=ex_alu_res (faulting address).
  - Legal: latch request, go to BUS.
- BUS: dmem_req=1; addr, we, be and wdata held stable. Timeout counter starts at 0 and increments each cycle without ack.
  - dmem_ack: capture result, wb_valid<=1, go to IDLE.
  - Counter reaches ACK_TIMEOUT-1 without ack: drop req, write back code 2 with wb_result=address, go to IDLE.
- HOLD: not entered in normal operation. On reset or any illegal encoding, state returns to IDLE.
- Store lanes:
  - SB: be=1<<addr[1:0], wdata={4{sd[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{sd[15:0]}}.
  - SW: be=4'hF, wdata=sd.
- Loads: be as for stores. Select byte/half by addr[1:0] from dmem_rdata.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word.
- Stores write back with wb_rd=0 and wb_result=0, so WB sees an ordered completion.
- wb_valid stays high with all wb_* stable until wb_ready.
- dmem_ack outside BUS is ignored.

## Timing
- Reset (async assert): state IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_be=0, wb_valid=0, wb_result=0, wb_rd=0, wb_exc=0, wb_exc_code=0, counter=0. ex_ready=1 from the first edge after deassertion.
- Reset mid-transaction aborts the access. dmem_req falls asynchronously and no writeback is produced.
- Non-memory latency: wb_valid in the cycle after accept. Throughput is 1 per cycle while wb_ready=1.
- Memory access:
  - dmem_req rises the cycle after accept.
  - Ack in the first req cycle gives wb_valid 2 cycles after accept.
  - Each wait cycle adds 1.
  - ex_ready=0 from accept until the cycle after completion.
- Timeout: wb_valid with code 2 exactly ACK_TIMEOUT+1 cycles after accept. An ack arriving in the same cycle as the terminal count wins: normal completion, no exception.
- Back-to-back memory ops: the next req rises no earlier than 2 cycles after the previous ack.

## Test plan
- Pass-through: ALU op with alu_res=0x12345678, rd=5, wb_ready=1 -> next cycle wb_valid=1, result 0x12345678, rd 5, wb_exc=0. Three consecutive ops complete on consecutive cycles.
- Loads: word at addr 0x100 = 0x80FF7F01, ack after 2 wait cycles.
  - LB @0x103 -> 0xFFFFFF80.
  - LBU @0x102 -> 0x000000FF.
  - LH @0x102 -> 0xFFFF80FF.
  - LW @0x100 -> 0x80FF7F01.
  - wb_valid 4 cycles after accept.
- Stores: SB @0x201 with data 0xAABBCCDD -> be=0010, wdata=0xDDDDDDDD, dmem_addr=0x200. SH @0x202 -> be=1100, wdata=0xCCDDCCDD. In both cases wb_rd=0 after ack.
- Exceptions:
  - LW @0x102 -> code 1, result 0x102, no dmem_req.
  - func3=3 load -> code 3.
  - ACK_TIMEOUT=4, no ack -> req high 4 cycles, then code 2.
- Backpressure and reset: hold wb_ready=0 -> ex_ready=0 and wb_* stable for 5 cycles. Assert rst_n=0 during BUS -> dmem_req drops in the same cycle, all outputs 0, no wb_valid after release.

Source files
------------

// File: rtl/r200_mem.sv
// r200 memory-access stage: single-outstanding data bus, byte lanes,
// load extension and a registered writeback slot toward WB.
module r200_mem #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_alu_res,
  input  logic [31:0] ex_store_data,
  input  logic [2:0]  ex_func3,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [4:0]  ex_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_rd,
  output logic        wb_exc,
  output logic [1:0]  wb_exc_code
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUS = 2'd1, S_HOLD = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   ea_q, ea_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic              wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]   wb_result_q, wb_result_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic              wb_exc_q, wb_exc_d;
  logic [1:0]        wb_exc_code_q, wb_exc_code_d;

  logic              accept;
  logic              op_illegal;
  logic              op_misaligned;
  logic [3:0]        op_be;
  logic [XLEN-1:0]   op_wdata;
  logic [4:0]        op_rd;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [XLEN-1:0]   ld_val;

  assign ex_ready    = (state_q == S_IDLE) && (!wb_valid_q || wb_ready);
  assign accept      = ex_valid && ex_ready;
  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = {ea_q[XLEN-1:2], 2'b00};
  assign dmem_wdata  = wdata_q;
  assign dmem_be     = be_q;
  assign wb_valid    = wb_valid_q;
  assign wb_result   = wb_result_q;
  assign wb_rd       = wb_rd_q;
  assign wb_exc      = wb_exc_q;
  assign wb_exc_code = wb_exc_code_q;

  // Decode legality, alignment and byte lanes of the incoming EX instruction
  always_comb begin
    op_illegal    = 1'b0;
    op_misaligned = 1'b0;
    op_be         = 4'h0;
    op_wdata      = '0;
    op_rd         = ex_store ? 5'd0 : ex_rd;
    if (ex_load && ex_store)  op_illegal = 1'b1;
    else if (ex_load)         op_illegal = (ex_func3 == 3'd3) || (ex_func3 >= 3'd6);
    else if (ex_store)        op_illegal = (ex_func3 > 3'd2);
    case (ex_func3[1:0])
      2'd0: begin
        op_be    = 4'b0001 << ex_alu_res[1:0];
        op_wdata = {4{ex_store_data[7:0]}};
      end
      2'd1: begin
        op_misaligned = ex_alu_res[0];
        op_be         = ex_alu_res[1] ? 4'b1100 : 4'b0011;
        op_wdata      = {2{ex_store_data[15:0]}};
      end
      default: begin
        op_misaligned = |ex_alu_res[1:0];
        op_be         = 4'hF;
        op_wdata      = ex_store_data;
      end
    endcase
    if (!ex_store) op_wdata = '0;
  end

  // Select and extend the addressed byte/half of the returned word
  always_comb begin
    ld_byte = 8'h00;
    case (ea_q[1:0])
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = ea_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_val  = dmem_rdata;
    case (f3_q)
      3'd0:    ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_val = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_val = {24'h000000, ld_byte};
      3'd5:    ld_val = {16'h0000, ld_half};
      default: ld_val = dmem_rdata;
    endcase
  end

  // Next-state, bus request and writeback slot
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_d         = req_q;
    we_d          = we_q;
    ea_d          = ea_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    f3_d          = f3_q;
    rd_d          = rd_q;
    wb_valid_d    = wb_valid_q;
    wb_result_d   = wb_result_q;
    wb_rd_d       = wb_rd_q;
    wb_exc_d      = wb_exc_q;
    wb_exc_code_d = wb_exc_code_q;

    if (wb_valid_q && wb_ready) wb_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!ex_load && !ex_store) begin
            wb_valid_d    = 1'b1;
            wb_result_d   = ex_alu_res;
            wb_rd_d       = ex_rd;
            wb_exc_d      = 1'b0;
            wb_exc_code_d = 2'd0;
          end else if (op_illegal) begin
            wb_valid_d    = 1'b1;
            wb_result_d   = '0;
            wb_rd_d       = op_rd;
            wb_exc_d      = 1'b1;
            wb_exc_code_d = 2'd3;
          end else if (op_misaligned) begin
            wb_valid_d    = 1'b1;
            wb_result_d   = ex_alu_res;
            wb_rd_d       = op_rd;
            wb_exc_d      = 1'b1;
            wb_exc_code_d = 2'd1;
          end else begin
            state_d = S_BUS;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = ex_store;
            ea_d    = ex_alu_res;
            wdata_d = op_wdata;
            be_d    = op_be;
            f3_d    = ex_func3;
            rd_d    = op_rd;
          end
        end
      end
      S_BUS: begin
        if (dmem_ack) begin
          state_d       = S_IDLE;
          req_d         = 1'b0;
          wb_valid_d    = 1'b1;
          wb_result_d   = we_q ? '0 : ld_val;
          wb_rd_d       = rd_q;
          wb_exc_d      = 1'b0;
          wb_exc_code_d = 2'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = S_IDLE;
          req_d         = 1'b0;
          wb_valid_d    = 1'b1;
          wb_result_d   = ea_q;
          wb_rd_d       = rd_q;
          wb_exc_d      = 1'b1;
          wb_exc_code_d = 2'd2;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any bus access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      ea_q          <= '0;
      wdata_q       <= '0;
      be_q          <= 4'h0;
      f3_q          <= 3'd0;
      rd_q          <= 5'd0;
      wb_valid_q    <= 1'b0;
      wb_result_q   <= '0;
      wb_rd_q       <= 5'd0;
      wb_exc_q      <= 1'b0;
      wb_exc_code_q <= 2'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_q         <= req_d;
      we_q          <= we_d;
      ea_q          <= ea_d;
      wdata_q       <= wdata_d;
      be_q          <= be_d;
      f3_q          <= f3_d;
      rd_q          <= rd_d;
      wb_valid_q    <= wb_valid_d;
      wb_result_q   <= wb_result_d;
      wb_rd_q       <= wb_rd_d;
      wb_exc_q      <= wb_exc_d;
      wb_exc_code_q <= wb_exc_code_d;
    end
  end

endmodule

// File: tb/tb_r200_mem.sv
// Self-checking bench for r200_mem: directed cases plus random ops
// against a byte-level memory model and RV32I load/store rules.
module tb_r200_mem;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_res;
  logic [31:0] ex_store_data;
  logic [2:0]  ex_func3;
  logic        ex_load;
  logic        ex_store;
  logic [4:0]  ex_rd;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd;
  logic        wb_exc;
  logic [1:0]  wb_exc_code;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [int unsigned];
  logic [2:0]  ld_f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  always #5 clk = ~clk;

  r200_mem #(.ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_res(ex_alu_res),
    .ex_store_data(ex_store_data), .ex_func3(ex_func3), .ex_load(ex_load),
    .ex_store(ex_store), .ex_rd(ex_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result),
    .wb_rd(wb_rd), .wb_exc(wb_exc), .wb_exc_code(wb_exc_code)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Word read from the model; untouched words return an address-derived pattern
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (mem.exists(wa)) return mem[wa];
    return wa ^ 32'h5A5A_0000;
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] data, input logic [2:0] f3);
    logic [31:0] w;
    int          nb;
    nb = 1 << f3[1:0];
    w  = mem_rd(a);
    for (int i = 0; i < nb; i++) w[8*(int'(a[1:0]) + i) +: 8] = data[8*i +: 8];
    mem[{a[31:2], 2'b00}] = w;
  endtask

  function automatic logic [31:0] load_val(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] off);
    int unsigned nb;
    logic [31:0] mask, v;
    nb   = 1 << f3[1:0];
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
    v    = (word >> (8*off)) & mask;
    if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // Present one instruction, act as the memory for it, and check the writeback
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                       input int w, output logic [31:0] res, output logic [3:0] obs_be,
                       output logic [31:0] obs_wd);
    logic        legal, mis, memop;
    int unsigned nb, nreq;
    logic [31:0] word, exp_res, exp_be, exp_wd;
    logic [1:0]  exp_code;
    memop  = ld | st;
    nb     = 1 << f3[1:0];
    legal  = !(ld && st) && !(ld && (f3 == 3'd3 || f3 > 3'd5)) && !(st && f3 > 3'd2);
    mis    = legal && memop && ((addr % nb) != 0);
    obs_be = 4'h0;
    obs_wd = 32'h0;
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_func3 = f3;
    ex_alu_res = addr; ex_store_data = sd; ex_rd = rd;
    for (int i = 0; i < 20 && !ex_ready; i++) @(posedge clk) #1;
    chk("ex_ready_accept", 32'(ex_ready), 32'd1);
    @(posedge clk) #1;
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_alu_res = $urandom;
    if (!memop || !legal || mis) begin
      exp_code = !memop ? 2'd0 : (!legal ? 2'd3 : 2'd1);
      exp_res  = (memop && !legal) ? 32'h0 : addr;
      chk("no_req", 32'(dmem_req), 32'd0);
    end else begin
      exp_be = 32'(((1 << nb) - 1) << addr[1:0]);
      exp_wd = (nb == 1) ? 32'(sd[7:0]) * 32'h0101_0101 :
               (nb == 2) ? 32'(sd[15:0]) * 32'h0001_0001 : sd;
      nreq   = (w < T) ? w + 1 : T;
      word   = mem_rd(addr);
      obs_be = dmem_be;
      obs_wd = dmem_wdata;
      for (int k = 0; k < int'(nreq); k++) begin
        chk("bus_req", 32'(dmem_req), 32'd1);
        chk("bus_addr", dmem_addr, {addr[31:2], 2'b00});
        chk("bus_we", 32'(dmem_we), 32'(st));
        chk("bus_be", 32'(dmem_be), exp_be);
        if (st) chk("bus_wdata", dmem_wdata, exp_wd);
        chk("ex_ready_busy", 32'(ex_ready), 32'd0);
        chk("wb_wait", 32'(wb_valid), 32'd0);
        dmem_ack   = (k == w);
        dmem_rdata = (k == w) ? word : $urandom;
        @(posedge clk) #1;
        dmem_ack = 1'b0;
      end
      chk("req_drop", 32'(dmem_req), 32'd0);
      if (w < T) begin
        exp_code = 2'd0;
        exp_res  = st ? 32'h0 : load_val(word, f3, addr[1:0]);
        if (st) mem_wr(addr, sd, f3);
      end else begin
        exp_code = 2'd2;
        exp_res  = addr;
      end
    end
    chk("wb_valid", 32'(wb_valid), 32'd1);
    chk("wb_result", wb_result, exp_res);
    chk("wb_exc", 32'(wb_exc), 32'(exp_code != 2'd0));
    chk("wb_exc_code", 32'(wb_exc_code), 32'(exp_code));
    if (exp_code == 2'd0) chk("wb_rd", 32'(wb_rd), st ? 32'd0 : 32'(rd));
    res = wb_result;
    @(posedge clk) #1;
    chk("wb_drain", 32'(wb_valid), 32'd0);
    chk("ex_ready_after", 32'(ex_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, wd, a;
    logic [3:0]  be;
    logic [2:0]  f3;
    logic        ld, st;
    int          kind;

    rst_n = 1'b0; ex_valid = 1'b0; ex_alu_res = '0; ex_store_data = '0; ex_func3 = '0;
    ex_load = 1'b0; ex_store = 1'b0; ex_rd = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    wb_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_result", wb_result, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_exc", {29'd0, wb_exc, wb_exc_code}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);

    // Back-to-back pass-through
    for (int i = 0; i < 3; i++) begin
      ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b0;
      ex_alu_res = 32'h1234_5678 + 32'(i); ex_rd = 5'(5 + i);
      chk("pt_ready", 32'(ex_ready), 32'd1);
      @(posedge clk) #1;
      chk("pt_valid", 32'(wb_valid), 32'd1);
      chk("pt_result", wb_result, 32'h1234_5678 + 32'(i));
      chk("pt_rd", 32'(wb_rd), 32'(5 + i));
      chk("pt_exc", 32'(wb_exc), 32'd0);
    end
    ex_valid = 1'b0;
    @(posedge clk) #1;
    chk("pt_drain", 32'(wb_valid), 32'd0);

    // Loads from a known word with two wait cycles
    mem[32'h100] = 32'h80FF_7F01;
    issue(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 5'd1, 2, r, be, wd);
    chk("lb_0x103", r, 32'hFFFF_FF80);
    issue(1'b1, 1'b0, 3'd4, 32'h102, 32'h0, 5'd2, 2, r, be, wd);
    chk("lbu_0x102", r, 32'h0000_00FF);
    issue(1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 5'd3, 2, r, be, wd);
    chk("lh_0x102", r, 32'hFFFF_80FF);
    issue(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 5'd4, 2, r, be, wd);
    chk("lw_0x100", r, 32'h80FF_7F01);

    // Store lanes
    issue(1'b0, 1'b1, 3'd0, 32'h201, 32'hAABB_CCDD, 5'd6, 1, r, be, wd);
    chk("sb_be", 32'(be), 32'h2);
    chk("sb_wdata", wd, 32'hDDDD_DDDD);
    issue(1'b0, 1'b1, 3'd1, 32'h202, 32'hAABB_CCDD, 5'd7, 0, r, be, wd);
    chk("sh_be", 32'(be), 32'hC);
    chk("sh_wdata", wd, 32'hCCDD_CCDD);

    // Exceptions: misaligned, illegal func3, timeout, ack on terminal count
    issue(1'b1, 1'b0, 3'd2, 32'h102, 32'h0, 5'd8, 0, r, be, wd);
    chk("misaligned_addr", r, 32'h102);
    issue(1'b1, 1'b0, 3'd3, 32'h100, 32'h0, 5'd8, 0, r, be, wd);
    chk("illegal_res", r, 32'h0);
    issue(1'b1, 1'b0, 3'd2, 32'h104, 32'h0, 5'd9, 99, r, be, wd);
    chk("timeout_addr", r, 32'h104);
    issue(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 5'd9, int'(T) - 1, r, be, wd);
    chk("late_ack", r, 32'h80FF_7F01);

    // Backpressure holds the writeback and blocks EX
    wb_ready = 1'b0;
    ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b0; ex_alu_res = 32'hCAFE_0001; ex_rd = 5'd9;
    @(posedge clk) #1;
    ex_alu_res = 32'h0BAD_0002; ex_rd = 5'd10;
    repeat (5) begin
      chk("bp_valid", 32'(wb_valid), 32'd1);
      chk("bp_ex_ready", 32'(ex_ready), 32'd0);
      chk("bp_result", wb_result, 32'hCAFE_0001);
      chk("bp_rd", 32'(wb_rd), 32'd9);
      @(posedge clk) #1;
    end
    wb_ready = 1'b1;
    #1;
    chk("bp_release", 32'(ex_ready), 32'd1);
    @(posedge clk) #1;
    ex_valid = 1'b0;
    chk("bp_next_result", wb_result, 32'h0BAD_0002);
    chk("bp_next_rd", 32'(wb_rd), 32'd10);
    @(posedge clk) #1;
    chk("bp_drain", 32'(wb_valid), 32'd0);

    // Reset in the middle of a bus access
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_func3 = 3'd2;
    ex_alu_res = 32'h100; ex_rd = 5'd3;
    @(posedge clk) #1;
    ex_valid = 1'b0; ex_load = 1'b0;
    chk("mid_req", 32'(dmem_req), 32'd1);
    @(posedge clk) #1;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(dmem_req), 32'd0);
    chk("arst_addr", dmem_addr, 32'd0);
    chk("arst_be", 32'(dmem_be), 32'd0);
    chk("arst_wb_valid", 32'(wb_valid), 32'd0);
    @(posedge clk) #1;
    rst_n = 1'b1;
    repeat (4) begin
      dmem_ack = 1'b1; dmem_rdata = $urandom;
      @(posedge clk) #1;
      chk("post_rst_wb", 32'(wb_valid), 32'd0);
      chk("post_rst_req", 32'(dmem_req), 32'd0);
    end
    dmem_ack = 1'b0;
    chk("post_rst_ready", 32'(ex_ready), 32'd1);

    // Random mix with stray acks between instructions
    for (int n = 0; n < 250; n++) begin
      dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
      @(posedge clk) #1;
      dmem_ack = 1'b0;
      chk("stray_ack_wb", 32'(wb_valid), 32'd0);
      chk("stray_ack_req", 32'(dmem_req), 32'd0);
      kind = int'($urandom_range(0, 9));
      ld = (kind >= 3 && kind <= 6);
      st = (kind == 7 || kind == 8);
      if (kind == 9) begin
        ld = 1'($urandom_range(0, 1));
        st = 1'($urandom_range(0, 1));
      end
      f3 = ld ? ld_f3s[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0 || kind == 9) f3 = 3'($urandom_range(0, 7));
      a = (ld || st) ? 32'h100 + 32'($urandom_range(0, 63)) : $urandom;
      issue(ld, st, f3, a, $urandom, 5'($urandom_range(0, 31)), int'($urandom_range(0, 5)),
            r, be, wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
